// File: rtl/seed_bank_pkg.sv
// Shared types and constants for the seed bank: FSM encoding, slot roles, word-count derivation.
// No logic; imported by the bank and its slot registers.
package seed_bank_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      LOAD = 1'b1
   } state_e;

   localparam int SLOT_RHO       = 0;
   localparam int SLOT_RHO_PRIME = 1;
   localparam int SLOT_KATA      = 2;

   function automatic int words_f(input int slot_w, input int word_w);
      return slot_w / word_w;
   endfunction

endpackage

// File: rtl/seed_bank_if.sv
// Load, clear and read signals of the seed bank; master drives requests, slave is the bank.
// Load words move on wr_valid & wr_ready; reads are registered with one cycle of latency.
interface seed_bank_if #(
   parameter int WORD_W     = 64,
   parameter int SLOT_W     = 512,
   parameter int NUM_SLOTS  = 3,
   parameter int SLOT_IDX_W = 2,
   parameter int LEN_W      = 4
);
   logic                  wr_start;
   logic [SLOT_IDX_W-1:0] wr_slot;
   logic [LEN_W-1:0]      wr_len;
   logic                  wr_valid;
   logic [WORD_W-1:0]     wr_data;
   logic                  wr_ready;
   logic                  busy;
   logic                  load_done;
   logic                  err;
   logic                  clr;
   logic [SLOT_IDX_W-1:0] clr_slot;
   logic [NUM_SLOTS-1:0]  slot_valid;
   logic [SLOT_IDX_W-1:0] rd_slot;
   logic [SLOT_W-1:0]     rd_data;

   modport master (
      output wr_start, wr_slot, wr_len, wr_valid, wr_data, clr, clr_slot, rd_slot,
      input  wr_ready, busy, load_done, err, slot_valid, rd_data
   );

   modport slave (
      input  wr_start, wr_slot, wr_len, wr_valid, wr_data, clr, clr_slot, rd_slot,
      output wr_ready, busy, load_done, err, slot_valid, rd_data
   );

endinterface

// File: rtl/seed_slot.sv
// One seed slot: SLOT_W register with per-word write enable, load-start zeroing and a valid flag.
// Updates on the next edge; with SEED_BANK_ZEROIZE_EN a clear also wipes the stored bits.
module seed_slot
   import seed_bank_pkg::*;
#(
   parameter  int WORD_W = 64,
   parameter  int SLOT_W = 512,
   localparam int WORDS  = words_f(SLOT_W, WORD_W)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              zero,
   input  logic              clr,
   input  logic              sel,
   input  logic              set_valid,
   input  logic [WORDS-1:0]  word_we,
   input  logic [WORD_W-1:0] wr_data,
   output logic [SLOT_W-1:0] data,
   output logic              valid
);

   logic [SLOT_W-1:0] dat_q, dat_d;
   logic              vld_q, vld_d;

   always_comb begin
      dat_d = dat_q;
      vld_d = vld_q;
      if (zero) begin
         dat_d = '0;
         vld_d = 1'b0;
      end else begin
         if (sel) begin
            for (int k = 0; k < WORDS; k++) begin
               if (word_we[k]) begin
                  dat_d[k*WORD_W +: WORD_W] = wr_data;
               end
            end
         end
         if (set_valid) begin
            vld_d = 1'b1;
         end else if (clr) begin
            vld_d = 1'b0;
`ifdef SEED_BANK_ZEROIZE_EN
            dat_d = '0;
`else
            dat_d = dat_d;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dat_q <= '0;
         vld_q <= 1'b0;
      end else begin
         dat_q <= dat_d;
         vld_q <= vld_d;
      end
   end

   assign data  = dat_q;
   assign valid = vld_q;

endmodule

// File: rtl/seed_bank.sv
// Multi-slot seed store loaded word-serially over valid/ready; registered full-width read, 1 cycle.
// Accepts every offered word while loading (no backpressure inside a load); SEED_BANK_ZEROIZE_EN wipes on clear.
module seed_bank
   import seed_bank_pkg::*;
#(
   parameter int WORD_W     = 64,
   parameter int SLOT_W     = 512,
   parameter int NUM_SLOTS  = 3,
   parameter int SLOT_IDX_W = 2,
   parameter int LEN_W      = 4
) (
   input  logic        clk,
   input  logic        reset,
   seed_bank_if.slave  bus
);

   localparam int                  WORDS   = words_f(SLOT_W, WORD_W);
   localparam logic [LEN_W-1:0]    WORDS_L = LEN_W'(WORDS);
   localparam logic [SLOT_IDX_W:0] SLOTS_L = (SLOT_IDX_W+1)'(NUM_SLOTS);

   state_e                state_q, state_d;
   logic [SLOT_IDX_W-1:0] slot_q, slot_d;
   logic [LEN_W-1:0]      len_q, len_d;
   logic [LEN_W-1:0]      cnt_q, cnt_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [SLOT_W-1:0]     rd_data_q, rd_data_d;

   logic [NUM_SLOTS-1:0]  zero_vec, set_vec, clr_vec, sel_vec, valid_vec;
   logic [WORDS-1:0]      word_we;
   logic [SLOT_W-1:0]     slot_dat [NUM_SLOTS];
   logic                  wr_slot_ok, clr_slot_ok, rd_slot_ok, clr_hits_load;

   assign wr_slot_ok  = {1'b0, bus.wr_slot}  < SLOTS_L;
   assign clr_slot_ok = {1'b0, bus.clr_slot} < SLOTS_L;
   assign rd_slot_ok  = {1'b0, bus.rd_slot}  < SLOTS_L;

   // The slot being filled cannot be invalidated under the loader's feet.
   assign clr_hits_load = (state_q == LOAD) && (bus.clr_slot == slot_q);
   assign clr_vec = (bus.clr && clr_slot_ok && !clr_hits_load) ?
                    (NUM_SLOTS'(1) << bus.clr_slot) : '0;
   assign sel_vec = NUM_SLOTS'(1) << slot_q;

   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      zero_vec = '0;
      set_vec  = '0;
      word_we  = '0;
      case (state_q)
         IDLE: begin
            if (bus.wr_start) begin
               if (wr_slot_ok) begin
                  slot_d   = bus.wr_slot;
                  len_d    = (bus.wr_len == '0 || bus.wr_len > WORDS_L) ? WORDS_L : bus.wr_len;
                  cnt_d    = '0;
                  zero_vec = NUM_SLOTS'(1) << bus.wr_slot;
                  state_d  = LOAD;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         LOAD: begin
            if (bus.wr_valid) begin
               word_we = WORDS'(1) << cnt_q;
               if (cnt_q == len_q - LEN_W'(1)) begin
                  set_vec = NUM_SLOTS'(1) << slot_q;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + LEN_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rd_data_d = '0;
      if (rd_slot_ok) begin
         rd_data_d = slot_dat[bus.rd_slot];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         slot_q    <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         slot_q    <= slot_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
         err_q     <= err_d;
         rd_data_q <= rd_data_d;
      end
   end

   for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
      seed_slot #(
         .WORD_W (WORD_W),
         .SLOT_W (SLOT_W)
      ) u_slot (
         .clk       (clk),
         .reset     (reset),
         .zero      (zero_vec[s]),
         .clr       (clr_vec[s]),
         .sel       (sel_vec[s]),
         .set_valid (set_vec[s]),
         .word_we   (word_we),
         .wr_data   (bus.wr_data),
         .data      (slot_dat[s]),
         .valid     (valid_vec[s])
      );
   end

   assign bus.wr_ready   = (state_q == LOAD);
   assign bus.busy       = (state_q == LOAD);
   assign bus.load_done  = done_q;
   assign bus.err        = err_q;
   assign bus.slot_valid = valid_vec;
   assign bus.rd_data    = rd_data_q;

endmodule

// File: doc/seed_bank.md
Name: seed_bank

Overview:
- Parametrised multi-slot seed store for the ML-DSA key/sign datapath. It holds rho, rho' and K, plus any further seeds if NUM_SLOTS is raised.
- Slots are loaded word-serially from the SHAKE squeeze stream over a valid/ready handshake. Each slot carries a valid flag.
- Any slot can be read full-width, registered, to the ExpandA/ExpandS/ExpandMask consumers.

Parameters:
- WORD_W, 64, width of one squeeze word (one Keccak lane).
- SLOT_W, 512, bits per slot; must be a multiple of WORD_W.
- NUM_SLOTS, 3, number of slots (0=rho, 1=rho', 2=K by convention).
- SLOT_IDX_W, 2, slot index width; $clog2(NUM_SLOTS), minimum 1.
- LEN_W, 4, word-count width; holds WORDS = SLOT_W/WORD_W.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_start  in  1  request a load; sampled only in IDLE.
- wr_slot  in  SLOT_IDX_W  target slot, sampled with wr_start.
- wr_len  in  LEN_W  words to load, sampled with wr_start.
- wr_valid  in  1  wr_data is valid.
- wr_data  in  WORD_W  squeeze word.
- wr_ready  out  1  bank accepts a word this cycle.
- busy  out  1  load in progress.
- load_done  out  1  one-cycle pulse when a load completes.
- err  out  1  one-cycle pulse when a start is rejected.
- clr  in  1  invalidate clr_slot.
- clr_slot  in  SLOT_IDX_W  slot to clear.
- slot_valid  out  NUM_SLOTS  per-slot valid flags.
- rd_slot  in  SLOT_IDX_W  read select.
- rd_data  out  SLOT_W  registered contents of rd_slot.

Behaviour:
- Reset (reset=0, asynchronous):
  - All slot storage zero; slot_valid, rd_data, wr_ready, busy, load_done, err all 0; FSM returns to IDLE.
  - A reset mid-load discards the partial load.
- FSM states: IDLE, LOAD.
- IDLE:
  - On wr_start with wr_slot < NUM_SLOTS:
    - latch slot and len_eff; len_eff = WORDS when wr_len is 0 or wr_len > WORDS, otherwise wr_len;
    - word counter := 0;
    - target slot storage zeroed, slot_valid[slot] := 0 (next edge);
    - go to LOAD.
  - On wr_start with wr_slot >= NUM_SLOTS: err=1 for one cycle; stay in IDLE; no state change.
- LOAD:
  - wr_ready=1 and busy=1.
  - A word is accepted on cycles with wr_valid & wr_ready. Word k is written to bits [k*WORD_W +: WORD_W], little-endian word order matching the byte-ordered squeeze.
  - Unloaded upper words stay zero (a 256-bit rho has words 4..7 = 0).
  - On acceptance of word len_eff-1: slot_valid[slot] := 1, load_done=1 on the following cycle, return to IDLE.
  - wr_valid gaps stall with no timeout.
  - wr_start is ignored in LOAD (no err).
- Back-to-back loads: a new wr_start is accepted in the IDLE cycle that coincides with the load_done pulse. Minimum 1 idle cycle between loads.
- clr:
  - Takes effect next edge: slot_valid[clr_slot] := 0.
  - Ignored if clr_slot >= NUM_SLOTS.
  - Ignored if clr_slot equals the slot being loaded while busy.
  - clr and load completion on different slots in the same cycle: both take effect.
- Read path:
  - rd_data <= storage[rd_slot] every cycle; 1-cycle latency.
  - rd_data = 0 for an out-of-range rd_slot.
  - A read during a load returns the current partial contents; consumers gate on slot_valid.
- Widths: the word counter is LEN_W bits and never wraps, because the load ends at len_eff-1.

Optional Feature:
- Macro: SEED_BANK_ZEROIZE_EN.
- Defined: clr also zeroes the slot storage on the same edge, so secrets are wiped.
- Not defined: clr only drops slot_valid, and storage keeps its old value until the next load.
- Load-start zeroing is unaffected in both cases.

Decomposition:
- Package seed_bank_pkg holds:
  - FSM state encoding (IDLE=0, LOAD=1);
  - slot index constants SLOT_RHO=0, SLOT_RHO_PRIME=1, SLOT_KATA=2;
  - the WORDS derivation function.
- One sub-module is natural: seed_slot. It is a single SLOT_W register with word-indexed write enable, zero and clear inputs, instantiated NUM_SLOTS times.

Test Plan:
- Reset, then load slot 0, wr_len=4, words 0x1111..,0x2222..,0x3333..,0x4444.. with no gaps -> load_done 4 cycles after the first accept, slot_valid=3'b001, rd_data[255:0] holds the four words in order, [511:256]=0.
- Load slot 1, wr_len=0, 8 words with wr_valid toggling 1/0 -> len clamped to 8, done after the 8th accept, slot_valid[1]=1, full 512 bits match.
- wr_start with wr_slot=3 -> err pulse, busy stays 0, slot_valid unchanged.
- During a slot-2 load: clr on slot 2 (ignored) and clr on slot 0 (slot_valid[0]->0) -> after completion slot_valid=3'b110.
- Reset asserted after 3 of 8 words -> all outputs 0 immediately, FSM in IDLE, a new load succeeds.
- With SEED_BANK_ZEROIZE_EN: clr slot 1 -> rd_data of slot 1 reads 0 one cycle later. Without the macro, the old data persists.
